mtm_alu_resp_receiver: RTL and testbench
========================================

Name: mtm_alu_resp_receiver

Overview:
- Downstream consumer of the ALU serial output `sout`.
- Deserializes the 11-bit response packets and reassembles them into either a result frame (32-bit C, 4 flags, 3-bit CRC) or an error frame (6 error flags, parity).
- Checks framing, packet sequence, CRC and parity, and presents each decoded response with a one-cycle valid pulse.
- Used in the chip-level testbench and in the on-board monitor wrapper.

Parameters:
- DATA_PKTS, 4, number of DATA packets preceding the CTL packet in a normal response.
- CRC_INIT, 3'b000, initial value of the CRC3 accumulator.

Ports:
- clk  in  1  posedge-active clock.
- rst  in  1  reset: one clock; asynchronous, active-high.
- sin  in  1  serial response line (driven by ALU `sout`); idle high.
- res_valid  out  1  one-cycle pulse: a complete response is decoded.
- res_err  out  1  1 = error frame, 0 = result frame (meaningful when res_valid).
- res_c  out  32  result C, MSB byte first on the line.
- res_flags  out  4  {carry, overflow, zero, negative} from the CTL packet.
- res_crc  out  3  received CRC field.
- res_crc_ok  out  1  received CRC equals CRC3 computed over {res_c, 1'b0, res_flags}.
- res_err_flags  out  6  error flags from the error CTL packet.
- res_par_ok  out  1  error CTL byte has even parity.
- proto_err  out  1  one-cycle pulse on a framing or sequence violation.

Behaviour:
- Packet format, one bit per clk, sampled at posedge:
  - start = 0, type (0 DATA, 1 CTL), 8 data bits MSB first, stop = 1.
  - 11 cycles per packet.
- Reset (async, rst=1):
  - FSM returns to IDLE; packet counter = 0; shift registers cleared.
  - All outputs = 0.
  - Deassertion takes effect at the next posedge. Reset mid-packet discards the partial response.
- FSM states: IDLE, TYPE, DATA, STOP.
  - IDLE: sin=0 sampled -> TYPE.
  - TYPE: latch type bit -> DATA; bit counter = 7.
  - DATA: shift sin into byte; counter 0 -> STOP.
  - STOP: evaluate the stop bit and the packet, then -> IDLE. A start bit can be sampled on the very next cycle (back-to-back packets, zero gap).
- Stop bit = 0: proto_err pulse; packet counter reset to 0; packet discarded; FSM -> IDLE.
- DATA packet:
  - cnt < DATA_PKTS: byte appended to C (C <= {C[23:0], byte}); cnt++.
  - cnt == DATA_PKTS: proto_err pulse; cnt = 0; packet dropped.
- CTL packet, cnt == DATA_PKTS and byte[7] = 0 (result frame):
  - res_flags = byte[6:3], res_crc = byte[2:0].
  - res_crc_ok evaluated; res_err = 0; cnt = 0.
- CTL packet, cnt == 0 and byte[7] = 1 (error frame):
  - res_err_flags = byte[6:1]; res_par_ok = ~^byte; res_err = 1.
- Any other CTL combination: proto_err pulse; cnt = 0; no res_valid.
- res_valid and proto_err are registered at the posedge that samples the stop bit and are high for exactly the following cycle.
- They are mutually exclusive. All res_* data outputs hold their values until the next res_valid.
- CRC3 uses polynomial x^3+x+1, computed over 37 bits MSB first from CRC_INIT. An implementation may compute it serially during reception or combinationally at the STOP state.
- A sin glitch back to 1 during TYPE or DATA is not checked; bits are taken as sampled.

Test Plan:
- Reset then sin held high 50 cycles -> all outputs 0; res_valid never asserts.
- Result frame, 4 DATA bytes 0x12,0x34,0x56,0x78 and CTL with flags 4'b0000 and correct CRC from the model, back-to-back -> single res_valid 1 cycle after the 55th bit; res_c=0x12345678, res_err=0, res_crc_ok=1.
- Same frame with CRC bit0 inverted -> res_valid, res_crc_ok=0, res_c unchanged.
- Error CTL byte 0xC9 (err_flags 6'b100100, parity 1) with no preceding DATA -> res_valid, res_err=1, res_err_flags=6'b100100, res_par_ok=1. Byte 0xC8 -> res_par_ok=0.
- Stop bit forced 0 on the 2nd DATA packet, then a full valid frame -> proto_err pulse after packet 2, no res_valid; next frame decodes correctly.
- Five DATA packets -> proto_err on the 5th. rst asserted mid-3rd packet -> outputs 0 immediately; subsequent frame decodes correctly.

Source files
------------

// File: rtl/mtm_alu_resp_receiver_if.sv
// Response-side bundle of the MTM ALU receiver: the serial line coming in
// and the decoded response fields going out.
//
// Handshake: there is no ready. res_valid and proto_err are single-cycle
// pulses, never high together; a consumer must capture on the cycle res_valid
// is high. The res_* data fields hold their values until the next res_valid.
interface mtm_alu_resp_receiver_if;
    logic        sin;
    logic        res_valid;
    logic        res_err;
    logic [31:0] res_c;
    logic [3:0]  res_flags;
    logic [2:0]  res_crc;
    logic        res_crc_ok;
    logic [5:0]  res_err_flags;
    logic        res_par_ok;
    logic        proto_err;
    logic [1:0]  dbg_state;

    // Line driver / response consumer side.
    modport master (
        output sin,
        input  res_valid, res_err, res_c, res_flags, res_crc, res_crc_ok,
        input  res_err_flags, res_par_ok, proto_err, dbg_state
    );

    // Receiver side.
    modport slave (
        input  sin,
        output res_valid, res_err, res_c, res_flags, res_crc, res_crc_ok,
        output res_err_flags, res_par_ok, proto_err, dbg_state
    );
endinterface

// File: rtl/mtm_alu_resp_receiver.sv
// MTM ALU response receiver: deserializes 11-bit packets from the ALU serial
// output, reassembles result frames (DATA_PKTS data bytes + CTL) or error
// frames (single CTL), checks framing, sequence, CRC3 and parity, and reports
// each decoded response with a one-cycle res_valid pulse.
module mtm_alu_resp_receiver #(
    parameter int unsigned DATA_PKTS = 4,
    parameter logic [2:0]  CRC_INIT  = 3'b000
) (
    input  logic                   clk,
    input  logic                   rst,
    mtm_alu_resp_receiver_if.slave bus
);

    localparam int CNT_W = (DATA_PKTS < 1) ? 1 : $clog2(DATA_PKTS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_PKTS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TYPE = 2'd1,
        ST_DATA = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    // CRC3, polynomial x^3+x+1, fed MSB first starting from CRC_INIT.
    function automatic logic [2:0] crc3(input logic [36:0] msg,
                                        input logic [2:0]  init);
        logic [2:0] crc;
        logic       fb;
        crc = init;
        for (int i = 36; i >= 0; i--) begin
            fb  = crc[2] ^ msg[i];
            crc = {crc[1], crc[0] ^ fb, fb};
        end
        return crc;
    endfunction

    // Packet deserializer state.
    state_t           state_q, state_d;
    logic             type_q, type_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       byte_q, byte_d;

    // Frame reassembly state.
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [31:0]      c_q, c_d;

    // Registered outputs.
    logic             res_valid_q, res_valid_d;
    logic             res_err_q, res_err_d;
    logic [31:0]      res_c_q, res_c_d;
    logic [3:0]       res_flags_q, res_flags_d;
    logic [2:0]       res_crc_q, res_crc_d;
    logic             res_crc_ok_q, res_crc_ok_d;
    logic [5:0]       res_err_flags_q, res_err_flags_d;
    logic             res_par_ok_q, res_par_ok_d;
    logic             proto_err_q, proto_err_d;

    // CRC over the completed frame as seen in STOP: C, a zero pad bit and the
    // four flags of the CTL byte just received.
    logic [2:0]       crc_calc;

    // Frame CRC is evaluated combinationally from the assembled C and flags.
    always_comb begin
        crc_calc = crc3({c_q, 1'b0, byte_q[6:3]}, CRC_INIT);
    end

    // Next-state logic: bit sampling, packet evaluation at the stop bit and
    // frame reassembly.
    always_comb begin
        state_d         = state_q;
        type_d          = type_q;
        bit_cnt_d       = bit_cnt_q;
        byte_d          = byte_q;
        pkt_cnt_d       = pkt_cnt_q;
        c_d             = c_q;
        res_valid_d     = 1'b0;
        proto_err_d     = 1'b0;
        res_err_d       = res_err_q;
        res_c_d         = res_c_q;
        res_flags_d     = res_flags_q;
        res_crc_d       = res_crc_q;
        res_crc_ok_d    = res_crc_ok_q;
        res_err_flags_d = res_err_flags_q;
        res_par_ok_d    = res_par_ok_q;

        case (state_q)
            ST_IDLE: begin
                if (!bus.sin) begin
                    state_d = ST_TYPE;
                end
            end

            ST_TYPE: begin
                type_d    = bus.sin;
                bit_cnt_d = 3'd7;
                state_d   = ST_DATA;
            end

            ST_DATA: begin
                byte_d = {byte_q[6:0], bus.sin};
                if (bit_cnt_q == 3'd0) begin
                    state_d = ST_STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q - 3'd1;
                end
            end

            ST_STOP: begin
                // Back to IDLE unconditionally so a start bit on the very
                // next cycle is caught.
                state_d = ST_IDLE;
                if (!bus.sin) begin
                    // Broken stop bit: drop the packet and the partial frame.
                    proto_err_d = 1'b1;
                    pkt_cnt_d   = '0;
                end else if (!type_q) begin
                    if (pkt_cnt_q < CNT_MAX) begin
                        c_d       = {c_q[23:0], byte_q};
                        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                    end else begin
                        // One DATA packet too many.
                        proto_err_d = 1'b1;
                        pkt_cnt_d   = '0;
                    end
                end else if ((pkt_cnt_q == CNT_MAX) && !byte_q[7]) begin
                    // Result frame.
                    res_valid_d  = 1'b1;
                    res_err_d    = 1'b0;
                    res_c_d      = c_q;
                    res_flags_d  = byte_q[6:3];
                    res_crc_d    = byte_q[2:0];
                    res_crc_ok_d = (crc_calc == byte_q[2:0]);
                    pkt_cnt_d    = '0;
                end else if ((pkt_cnt_q == '0) && byte_q[7]) begin
                    // Error frame: a lone CTL packet.
                    res_valid_d     = 1'b1;
                    res_err_d       = 1'b1;
                    res_err_flags_d = byte_q[6:1];
                    res_par_ok_d    = ~^byte_q;
                    pkt_cnt_d       = '0;
                end else begin
                    // CTL at the wrong place in the sequence.
                    proto_err_d = 1'b1;
                    pkt_cnt_d   = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All state and outputs registered; asynchronous reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            type_q          <= 1'b0;
            bit_cnt_q       <= 3'd0;
            byte_q          <= 8'd0;
            pkt_cnt_q       <= '0;
            c_q             <= 32'd0;
            res_valid_q     <= 1'b0;
            res_err_q       <= 1'b0;
            res_c_q         <= 32'd0;
            res_flags_q     <= 4'd0;
            res_crc_q       <= 3'd0;
            res_crc_ok_q    <= 1'b0;
            res_err_flags_q <= 6'd0;
            res_par_ok_q    <= 1'b0;
            proto_err_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            type_q          <= type_d;
            bit_cnt_q       <= bit_cnt_d;
            byte_q          <= byte_d;
            pkt_cnt_q       <= pkt_cnt_d;
            c_q             <= c_d;
            res_valid_q     <= res_valid_d;
            res_err_q       <= res_err_d;
            res_c_q         <= res_c_d;
            res_flags_q     <= res_flags_d;
            res_crc_q       <= res_crc_d;
            res_crc_ok_q    <= res_crc_ok_d;
            res_err_flags_q <= res_err_flags_d;
            res_par_ok_q    <= res_par_ok_d;
            proto_err_q     <= proto_err_d;
        end
    end

    assign bus.res_valid     = res_valid_q;
    assign bus.res_err       = res_err_q;
    assign bus.res_c         = res_c_q;
    assign bus.res_flags     = res_flags_q;
    assign bus.res_crc       = res_crc_q;
    assign bus.res_crc_ok    = res_crc_ok_q;
    assign bus.res_err_flags = res_err_flags_q;
    assign bus.res_par_ok    = res_par_ok_q;
    assign bus.proto_err     = proto_err_q;
    assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_mtm_alu_resp_receiver.sv
// Bench for mtm_alu_resp_receiver: directed scenarios plus randomized packet
// streams, checked against a frame-level reference model and scoreboard.
module tb_mtm_alu_resp_receiver;
  localparam int DATA_PKTS = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mtm_alu_resp_receiver_if bus ();

  mtm_alu_resp_receiver #(
    .DATA_PKTS (DATA_PKTS),
    .CRC_INIT  (3'b000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_proto  = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_res_valid"},     bus.res_valid, 0);
    check_eq({tag, "_res_err"},       bus.res_err, 0);
    check_eq({tag, "_res_c"},         bus.res_c, 0);
    check_eq({tag, "_res_flags"},     bus.res_flags, 0);
    check_eq({tag, "_res_crc"},       bus.res_crc, 0);
    check_eq({tag, "_res_crc_ok"},    bus.res_crc_ok, 0);
    check_eq({tag, "_res_err_flags"}, bus.res_err_flags, 0);
    check_eq({tag, "_res_par_ok"},    bus.res_par_ok, 0);
    check_eq({tag, "_proto_err"},     bus.proto_err, 0);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          cyc;
    logic        proto;
    logic        err;
    logic [31:0] c;
    logic [3:0]  flags;
    logic [2:0]  crc;
    logic        crc_ok;
    logic [5:0]  eflags;
    logic        par_ok;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] data_bytes[$];
  logic        h_err;
  logic [31:0] h_c;
  logic [3:0]  h_flags;
  logic [2:0]  h_crc;
  logic        h_crc_ok;
  logic [5:0]  h_eflags;
  logic        h_par_ok;

  // Remainder of (msg * x^3) modulo x^3+x+1 by polynomial long division.
  function automatic logic [2:0] model_crc(input logic [31:0] c, input logic [3:0] flags);
    logic [39:0] val;
    logic [39:0] poly;
    val = {c, 1'b0, flags, 3'b000};
    for (int i = 39; i >= 3; i--) begin
      if (val[i]) begin
        poly = 40'b1011 << (i - 3);
        val  = val ^ poly;
      end
    end
    return val[2:0];
  endfunction

  task automatic model_reset();
    data_bytes.delete();
    exp_q.delete();
    h_err = 0; h_c = 0; h_flags = 0; h_crc = 0; h_crc_ok = 0; h_eflags = 0; h_par_ok = 0;
  endtask

  // Called while the stop bit is on the line; the response appears next cycle.
  task automatic model_packet(input logic typ, input logic [7:0] b, input logic stop_ok);
    exp_t e;
    logic ev;
    ev = 1'b1;
    e.proto = 1'b0;
    if (!stop_ok) begin
      e.proto = 1'b1;
      data_bytes.delete();
    end else if (!typ) begin
      if (data_bytes.size() < DATA_PKTS) begin
        data_bytes.push_back(b);
        ev = 1'b0;
      end else begin
        e.proto = 1'b1;
        data_bytes.delete();
      end
    end else if (data_bytes.size() == DATA_PKTS && !b[7]) begin
      h_c = 0;
      foreach (data_bytes[i]) h_c = (h_c << 8) | 32'(data_bytes[i]);
      h_err    = 1'b0;
      h_flags  = b[6:3];
      h_crc    = b[2:0];
      h_crc_ok = (model_crc(h_c, h_flags) == b[2:0]);
      data_bytes.delete();
    end else if (data_bytes.size() == 0 && b[7]) begin
      h_err    = 1'b1;
      h_eflags = b[6:1];
      h_par_ok = ($countones(b) % 2 == 0);
    end else begin
      e.proto = 1'b1;
      data_bytes.delete();
    end
    if (ev) begin
      e.cyc = cyc + 1;
      e.err = h_err; e.c = h_c; e.flags = h_flags; e.crc = h_crc;
      e.crc_ok = h_crc_ok; e.eflags = h_eflags; e.par_ok = h_par_ok;
      exp_q.push_back(e);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.res_valid || bus.proto_err)) begin
      if (bus.res_valid) n_valid++;
      if (bus.proto_err) n_proto++;
      check_eq("valid_proto_exclusive", bus.res_valid & bus.proto_err, 0);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_event", {bus.res_valid, bus.proto_err}, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("event_cycle", cyc, e.cyc);
        check_eq("proto_err", bus.proto_err, e.proto);
        check_eq("res_valid", bus.res_valid, !e.proto);
        check_eq("res_err", bus.res_err, e.err);
        check_eq("res_c", bus.res_c, e.c);
        check_eq("res_flags", bus.res_flags, e.flags);
        check_eq("res_crc", bus.res_crc, e.crc);
        check_eq("res_crc_ok", bus.res_crc_ok, e.crc_ok);
        check_eq("res_err_flags", bus.res_err_flags, e.eflags);
        check_eq("res_par_ok", bus.res_par_ok, e.par_ok);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b);
    @(negedge clk);
    bus.sin = b;
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic send_packet(input logic typ, input logic [7:0] b, input logic stop_ok);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    @(negedge clk);
    bus.sin = stop_ok;
    model_packet(typ, b, stop_ok);
  endtask

  task automatic send_frame(input logic [31:0] c, input logic [3:0] flags, input logic [2:0] crc_xor);
    logic [2:0] crc;
    crc = model_crc(c, flags) ^ crc_xor;
    for (int i = 3; i >= 0; i--) send_packet(1'b0, c[8*i +: 8], 1'b1);
    send_packet(1'b1, {1'b0, flags, crc}, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.sin = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pv, pp;
    logic [7:0] b;
    bus.sin = 1'b1;
    model_reset();
    do_reset();
    check_zero("reset");

    // Idle line must produce nothing.
    idle(50);
    check_zero("idle");
    check_eq("idle_no_events", n_valid + n_proto, 0);

    // Directed result frame.
    send_frame(32'h12345678, 4'b0000, 3'b000);
    idle(3);
    check_eq("dir_res_c", bus.res_c, 32'h12345678);
    check_eq("dir_res_err", bus.res_err, 0);
    check_eq("dir_crc_ok", bus.res_crc_ok, 1);
    check_eq("dir_valid_count", n_valid, 1);

    // Same frame, CRC bit0 inverted, sent back-to-back.
    send_frame(32'h12345678, 4'b0000, 3'b001);
    idle(2);
    check_eq("badcrc_crc_ok", bus.res_crc_ok, 0);
    check_eq("badcrc_res_c", bus.res_c, 32'h12345678);

    // Error frames.
    send_packet(1'b1, 8'hC9, 1'b1);
    idle(2);
    check_eq("err_c9_res_err", bus.res_err, 1);
    check_eq("err_c9_flags", bus.res_err_flags, 6'b100100);
    check_eq("err_c9_par_ok", bus.res_par_ok, 1);
    send_packet(1'b1, 8'hC8, 1'b1);
    idle(2);
    check_eq("err_c8_par_ok", bus.res_par_ok, 0);

    // Broken stop bit on 2nd DATA packet, then a good frame.
    pv = n_valid; pp = n_proto;
    send_packet(1'b0, 8'hA1, 1'b1);
    send_packet(1'b0, 8'hA2, 1'b0);
    send_frame(32'hDEADBEEF, 4'b1010, 3'b000);
    idle(3);
    check_eq("stop0_proto_count", n_proto - pp, 1);
    check_eq("stop0_valid_count", n_valid - pv, 1);
    check_eq("stop0_next_c", bus.res_c, 32'hDEADBEEF);
    check_eq("stop0_next_flags", bus.res_flags, 4'b1010);

    // Five DATA packets: the fifth is a sequence violation.
    pv = n_valid; pp = n_proto;
    for (int i = 0; i < 5; i++) send_packet(1'b0, 8'(i + 1), 1'b1);
    idle(3);
    check_eq("five_data_proto", n_proto - pp, 1);
    check_eq("five_data_valid", n_valid - pv, 0);

    // Reset in the middle of the 3rd DATA packet.
    send_frame(32'hCAFEF00D, 4'b0110, 3'b000);
    send_packet(1'b0, 8'h11, 1'b1);
    send_packet(1'b0, 8'h22, 1'b1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_zero("midrst");
    @(negedge clk);
    bus.sin = 1'b1;
    rst = 1'b0;
    idle(2);
    check_zero("after_midrst");
    send_frame(32'h0BADC0DE, 4'b1111, 3'b000);
    idle(3);
    check_eq("midrst_next_c", bus.res_c, 32'h0BADC0DE);
    check_eq("midrst_next_crc_ok", bus.res_crc_ok, 1);

    // Randomized mix of frames and stray packets.
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 3))
        0, 1: send_frame($urandom, 4'($urandom_range(0, 15)),
                         ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0);
        2: begin
          b = 8'($urandom_range(128, 255));
          send_packet(1'b1, b, 1'b1);
        end
        default: begin
          b = 8'($urandom_range(0, 255));
          send_packet(1'($urandom_range(0, 1)), b, $urandom_range(0, 7) != 0);
        end
      endcase
      idle($urandom_range(0, 3));
    end

    idle(5);
    check_eq("pending_events", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
